// File: rtl/window_pos_pkg.sv
// Shared types for the window position tracker.
// The entry layout is sized from the default image geometry below.
package window_pos_pkg;

  localparam int DEF_IMG_WIDTH  = 45;
  localparam int DEF_IMG_HEIGHT = 45;
  localparam int DEF_N_SCALES   = 4;

  function automatic int w_coord_of(input int n);
    return $clog2(n);
  endfunction

  // A single scale still needs one bit so the field never has zero width.
  function automatic int w_scale_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ENTRY_W_X = w_coord_of(DEF_IMG_WIDTH);
  localparam int ENTRY_W_Y = w_coord_of(DEF_IMG_HEIGHT);
  localparam int ENTRY_W_S = w_scale_of(DEF_N_SCALES);

  typedef struct packed {
    logic [ENTRY_W_X-1:0] x;
    logic [ENTRY_W_Y-1:0] y;
    logic [ENTRY_W_S-1:0] scale;
    logic                 last;
  } pos_entry_t;

endpackage

// File: rtl/pos_fifo.sv
// Synchronous FIFO with first-word fall-through read data and an
// occupancy count; push when full and pop when empty are ignored.
module pos_fifo
  import window_pos_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = pos_entry_t,
  localparam int W_D   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  T             data_i,
  input  logic         pop_i,
  output T             data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [W_D:0] count_o
);

  T               mem_q [DEPTH];
  logic [W_D-1:0] wr_ptr_q, wr_ptr_d;
  logic [W_D-1:0] rd_ptr_q, rd_ptr_d;
  logic [W_D:0]   count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == (W_D+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/detect_pos_tracker.sv
// Queues scanned window positions, pairs in-order classifier results with
// them, emits positive detections and a per-frame detection count.
module detect_pos_tracker
  import window_pos_pkg::*;
#(
  parameter int  IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int  IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int  N_SCALES   = DEF_N_SCALES,
  parameter int  DEPTH      = 8,
  parameter int  MAX_DET    = 255,
  localparam int W_X        = w_coord_of(IMG_WIDTH),
  localparam int W_Y        = w_coord_of(IMG_HEIGHT),
  localparam int W_S        = w_scale_of(N_SCALES),
  localparam int W_D        = $clog2(DEPTH),
  localparam int W_C        = $clog2(MAX_DET + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           window_pos_valid,
  output logic           window_pos_ready,
  input  logic [W_X-1:0] window_pos_x,
  input  logic [W_Y-1:0] window_pos_y,
  input  logic [W_S-1:0] window_pos_scale,
  input  logic           window_pos_last,
  input  logic           result_valid,
  output logic           result_ready,
  input  logic           result,
  output logic           detect_pos_valid,
  input  logic           detect_pos_ready,
  output logic [W_X-1:0] detect_pos_x,
  output logic [W_Y-1:0] detect_pos_y,
  output logic [W_S-1:0] detect_pos_scale,
  output logic           frame_done_valid,
  input  logic           frame_done_ready,
  output logic [W_C-1:0] frame_det_count,
  output logic [W_D:0]   occupancy
);

  pos_entry_t     push_entry, head;
  logic           fifo_full, fifo_empty;
  logic           push, retire;

  logic           det_valid_q, det_valid_d;
  logic [W_X-1:0] det_x_q, det_x_d;
  logic [W_Y-1:0] det_y_q, det_y_d;
  logic [W_S-1:0] det_s_q, det_s_d;
  logic           fd_valid_q, fd_valid_d;
  logic [W_C-1:0] fd_count_q, fd_count_d;
  logic [W_C-1:0] counter_q, counter_d;
  logic [W_C-1:0] counter_inc;

  assign push_entry = '{x: window_pos_x, y: window_pos_y,
                        scale: window_pos_scale, last: window_pos_last};

  assign window_pos_ready = ~fifo_full;
  assign push             = window_pos_valid & window_pos_ready;

  // A pending, unaccepted output on either channel holds off the next retire.
  assign result_ready = ~fifo_empty
                      & (~det_valid_q | detect_pos_ready)
                      & (~fd_valid_q | frame_done_ready);
  assign retire       = result_valid & result_ready;

  pos_fifo #(
    .DEPTH (DEPTH),
    .T     (pos_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (retire),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  assign counter_inc = (counter_q == W_C'(MAX_DET)) ? counter_q : counter_q + 1'b1;

  always_comb begin
    det_valid_d = det_valid_q;
    det_x_d     = det_x_q;
    det_y_d     = det_y_q;
    det_s_d     = det_s_q;
    fd_valid_d  = fd_valid_q;
    fd_count_d  = fd_count_q;
    counter_d   = counter_q;

    if (retire && result) begin
      det_valid_d = 1'b1;
      det_x_d     = head.x;
      det_y_d     = head.y;
      det_s_d     = head.scale;
    end else if (detect_pos_ready) begin
      det_valid_d = 1'b0;
    end

    if (retire && head.last) begin
      fd_valid_d = 1'b1;
      fd_count_d = result ? counter_inc : counter_q;
      counter_d  = '0;
    end else begin
      if (frame_done_ready) fd_valid_d = 1'b0;
      if (retire && result) counter_d = counter_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_valid_q <= 1'b0;
      det_x_q     <= '0;
      det_y_q     <= '0;
      det_s_q     <= '0;
      fd_valid_q  <= 1'b0;
      fd_count_q  <= '0;
      counter_q   <= '0;
    end else begin
      det_valid_q <= det_valid_d;
      det_x_q     <= det_x_d;
      det_y_q     <= det_y_d;
      det_s_q     <= det_s_d;
      fd_valid_q  <= fd_valid_d;
      fd_count_q  <= fd_count_d;
      counter_q   <= counter_d;
    end
  end

  assign detect_pos_valid = det_valid_q;
  assign detect_pos_x     = det_x_q;
  assign detect_pos_y     = det_y_q;
  assign detect_pos_scale = det_s_q;
  assign frame_done_valid = fd_valid_q;
  assign frame_det_count  = fd_count_q;

endmodule

// File: doc/detect_pos_tracker.md
Name: detect_pos_tracker

Overview:
- Multi-outstanding successor to the single-register window position tracker.
- Sits between the window scanner and the cascade classifier output stage.
- Queues up to DEPTH window positions (x, y, scale, frame-last flag) that the classifier is still evaluating. Pairs each in-order classifier result with its queued position and emits only positive detections.
- Reports a per-frame detection count when the last window of a frame retires.

Parameters:
- IMG_WIDTH, 45, image width in pixels; W_X = $clog2(IMG_WIDTH).
- IMG_HEIGHT, 45, image height in pixels; W_Y = $clog2(IMG_HEIGHT).
- N_SCALES, 4, number of pyramid scales; W_S = max(1, $clog2(N_SCALES)).
- DEPTH, 8, position FIFO depth, power of two, >= 2; W_D = $clog2(DEPTH).
- MAX_DET, 255, saturation value of the per-frame detection counter; W_C = $clog2(MAX_DET+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- window_pos_valid  in  1  scanner offers a window position.
- window_pos_ready  out  1  FIFO can accept.
- window_pos_x  in  W_X  window x.
- window_pos_y  in  W_Y  window y.
- window_pos_scale  in  W_S  pyramid scale index.
- window_pos_last  in  1  last window of the frame.
- result_valid  in  1  classifier result available.
- result_ready  out  1  result consumed this cycle.
- result  in  1  1 = face detected.
- detect_pos_valid  out  1  detection output valid.
- detect_pos_ready  in  1  downstream accepts the detection.
- detect_pos_x  out  W_X  detected x.
- detect_pos_y  out  W_Y  detected y.
- detect_pos_scale  out  W_S  detected scale.
- frame_done_valid  out  1  frame summary valid.
- frame_done_ready  in  1  downstream accepts the summary.
- frame_det_count  out  W_C  detections in the completed frame.
- occupancy  out  W_D+1  number of queued positions.

Behaviour:
- Reset: FIFO empty, occupancy=0; detect_pos_valid=0 with x/y/scale=0; frame_done_valid=0, frame_det_count=0; internal counter=0. Reset mid-frame discards all queued positions and the partial count.
- Push: window_pos_ready = (occupancy != DEPTH). It does not depend on a same-cycle pop. Push on window_pos_valid & window_pos_ready.
- Retire: result_ready = (occupancy != 0) & (!detect_pos_valid | detect_pos_ready) & (!frame_done_valid | frame_done_ready). Retire on result_valid & result_ready, which pops the FIFO head. A result arriving with an empty FIFO stalls; it is never dropped.
- Ordering: results map to positions strictly in FIFO order.
- Detection output: on retire with result=1, the head x/y/scale are registered into detect_pos_* and detect_pos_valid=1 the next cycle (latency 1). A retire with result=0 produces no output. detect_pos_valid clears on detect_pos_ready unless reloaded the same cycle. Outputs are held stable while valid & !ready.
- Counter: increments on each retire with result=1 and saturates at MAX_DET.
- Frame done: on retire of an entry with last=1:
  - frame_det_count loads counter + (result ? 1 : 0), saturated.
  - frame_done_valid=1 next cycle.
  - The internal counter clears to 0 in that same cycle.
  - A frame with zero detections reports 0.
  - frame_done_valid clears on frame_done_ready.
- Simultaneous events:
  - Push and pop in the same cycle leave occupancy unchanged.
  - Push and pop at full are impossible, because ready is low.
  - A last=1 retire with result=1 raises both detect_pos_valid and frame_done_valid in the same cycle.
- Backpressure: an asserted-but-unaccepted output on either channel blocks further retires. Pushes continue until the FIFO is full.
- Occupancy: reflects the registered state (post-update value, visible the cycle after the handshake).

Decomposition:
- Package window_pos_pkg holds:
  - W_X, W_Y, W_S helpers as functions of the parameters.
  - Packed struct pos_entry_t {x, y, scale, last}.
- Sub-module pos_fifo: a generic synchronous FIFO (DEPTH, data type pos_entry_t) with push/pop/full/empty/count. The top module holds the output registers, counter and handshake logic.

Test Plan:
- Push (3,4,s0),(5,6,s1),(7,8,s2,last) then results 1,0,1 -> detections (3,4,0) and (7,8,2), each 1 cycle after its retire; frame_det_count=2.
- Push 8 positions, no results -> occupancy=8, window_pos_ready=0; the 9th valid waits. One retire -> ready=1 the next cycle.
- result_valid=1 with empty FIFO for 5 cycles -> result_ready=0 throughout, no output. Push (1,1) -> the retire occurs and the result is not lost.
- Hold detect_pos_ready=0 after a detection -> result_ready=0 and outputs stable for 10 cycles. Raise ready -> the next result retires the same cycle.
- Frame of 300 positive windows with MAX_DET=255 -> frame_det_count=255. The next frame with 0 detections -> frame_det_count=0.
- Assert rst with 4 queued and counter=3 -> occupancy=0, all valids 0. A new frame (last window, result=1) -> count=1.
